// File: rtl/vppm_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : vppm_frame_tx
// Brief    : VPPM transmit framer/modulator (preamble, sync, MSB-first data,
//            back-to-back words streamed without a new preamble).
// Revision : 1.0
// ============================================================================
module vppm_frame_tx #(
  parameter int NBITS         = 12,
  parameter int PERIOD_CYC    = 40,
  parameter int DUTY_CYC      = 20,
  parameter int PREAMBLE_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             vppm_out,
  output logic             busy
);

  localparam int CW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int BMAX = (NBITS > PREAMBLE_BITS) ? NBITS : PREAMBLE_BITS;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] C_LAST     = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] C_DUTY     = CW'(DUTY_CYC);
  localparam logic [CW-1:0] C_ONE_RISE = CW'(PERIOD_CYC - DUTY_CYC);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] C_BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] C_DATA_END = BW'(NBITS - 1);
  localparam logic [BW-1:0] C_PRE_END  = BW'(PREAMBLE_BITS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_SYNC     = 2'd2;
  localparam logic [1:0] S_DATA     = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bit;
  logic [NBITS-1:0] r_shift;
  logic             r_vppm;

  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [BW-1:0]    w_bit_nxt;
  logic [NBITS-1:0] w_shift_nxt;
  logic [NBITS-1:0] w_shift_left;
  logic             w_vppm_nxt;
  logic             w_sym_one;
  logic             w_sym_end;
  logic             w_last_data;
  logic             w_xfer;

  assign w_sym_end   = (r_cnt == C_LAST);
  assign w_last_data = (r_state == S_DATA) && (r_bit == C_DATA_END) && w_sym_end;

  // Ready is gated by reset so nothing is accepted while rst_n is low.
  assign tx_ready = rst_n && ((r_state == S_IDLE) || w_last_data);
  assign w_xfer   = tx_valid && tx_ready;
  assign busy     = (r_state != S_IDLE);
  assign vppm_out = r_vppm;

  generate
    if (NBITS > 1) begin : g_shift_multi
      assign w_shift_left = {r_shift[NBITS-2:0], 1'b0};
    end else begin : g_shift_single
      assign w_shift_left = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_xfer) begin
          w_state_nxt = S_PREAMBLE;
          w_shift_nxt = tx_data;
        end
      end
      S_PREAMBLE: begin
        if (w_sym_end) begin
          w_cnt_nxt = '0;
          if (r_bit == C_PRE_END) begin
            w_state_nxt = S_SYNC;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + C_BIT_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      S_SYNC: begin
        if (w_sym_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      S_DATA: begin
        if (w_sym_end) begin
          w_cnt_nxt = '0;
          if (r_bit == C_DATA_END) begin
            w_bit_nxt = '0;
            // A word taken on the final-cycle ready pulse continues the stream.
            if (w_xfer) begin
              w_shift_nxt = tx_data;
            end else begin
              w_state_nxt = S_IDLE;
              w_shift_nxt = '0;
            end
          end else begin
            w_bit_nxt   = r_bit + C_BIT_ONE;
            w_shift_nxt = w_shift_left;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_shift_nxt = '0;
      end
    endcase
  end

  // The output is encoded from next-state values so vppm_out lines up with the counters.
  always_comb begin
    w_sym_one  = 1'b0;
    w_vppm_nxt = 1'b0;
    if (w_state_nxt == S_DATA) begin
      w_sym_one = w_shift_nxt[NBITS-1];
    end
    if (w_state_nxt != S_IDLE) begin
      w_vppm_nxt = w_sym_one ? (w_cnt_nxt >= C_ONE_RISE) : (w_cnt_nxt < C_DUTY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vppm  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_vppm  <= w_vppm_nxt;
    end
  end

endmodule
`default_nettype wire
